// File: rtl/square_root32_result_fifo.sv
// Result FIFO behind the square_root32 pipeline; captures root and remainder.
// Define SQUARE_ROOT32_RESULT_FIFO_REMAINDER_EN to compute and store remainders.
module square_root32_result_fifo #(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iFLUSH,
    input  logic                 iDATA_REQ,
    output logic                 oDATA_BUSY,
    input  logic [15:0]          iDATA_ROOT,
    input  logic [31:0]          iDATA_I,
    output logic                 oDATA_VALID,
    input  logic                 iDATA_BUSY,
    output logic [15:0]          oDATA_ROOT,
    output logic [16:0]          oDATA_REM,
    output logic [P_DEPTH_N:0]   oCOUNT
);

    localparam logic [P_DEPTH_N:0] LP_FULL = (P_DEPTH_N + 1)'(P_DEPTH);

    logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_DEPTH_N:0]   count_q, count_d;
    logic [15:0]          root_mem_q [P_DEPTH];
    logic                 push;
    logic                 pop;

    assign oDATA_BUSY  = (count_q == LP_FULL);
    assign oDATA_VALID = (count_q != '0);
    assign oCOUNT      = count_q;
    assign oDATA_ROOT  = root_mem_q[rd_ptr_q];

    // Busy is registered-only, so a pop cannot free a slot for a same-cycle push.
    assign push = iDATA_REQ && !oDATA_BUSY && !iFLUSH;
    assign pop  = oDATA_VALID && !iDATA_BUSY && !iFLUSH;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iFLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + P_DEPTH_N'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + P_DEPTH_N'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (P_DEPTH_N + 1)'(1);
                2'b01:   count_d = count_q - (P_DEPTH_N + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < P_DEPTH; i++) begin
                root_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                root_mem_q[wr_ptr_q] <= iDATA_ROOT;
            end
        end
    end

`ifdef SQUARE_ROOT32_RESULT_FIFO_REMAINDER_EN
    logic [31:0] square;
    logic [31:0] rem_full;
    logic [16:0] rem_mem_q [P_DEPTH];

    // Wrapping 32-bit difference; only the low 17 bits are meaningful.
    assign square   = {16'h0, iDATA_ROOT} * {16'h0, iDATA_ROOT};
    assign rem_full = iDATA_I - square;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                rem_mem_q[i] <= '0;
            end
        end else if (push) begin
            rem_mem_q[wr_ptr_q] <= rem_full[16:0];
        end
    end

    assign oDATA_REM = rem_mem_q[rd_ptr_q];
`else
    logic unused_data_i;

    assign unused_data_i = ^iDATA_I;
    assign oDATA_REM     = 17'h0;
`endif

endmodule

// File: tb/tb_square_root32_result_fifo.sv
// Directed bench for square_root32_result_fifo.
// Remainder expectations follow SQUARE_ROOT32_RESULT_FIFO_REMAINDER_EN.
module tb_square_root32_result_fifo;

`ifdef SQUARE_ROOT32_RESULT_FIFO_REMAINDER_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req;
    logic        busy_o;
    logic [15:0] root_i;
    logic [31:0] rad_i;
    logic        valid_o;
    logic        busy_i;
    logic [15:0] root_o;
    logic [16:0] rem_o;
    logic [2:0]  count_o;

    int n_tests = 0;
    int n_fail  = 0;

    square_root32_result_fifo #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
        .iCLOCK      (clk),
        .inRESET     (rst_n),
        .iFLUSH      (flush),
        .iDATA_REQ   (req),
        .oDATA_BUSY  (busy_o),
        .iDATA_ROOT  (root_i),
        .iDATA_I     (rad_i),
        .oDATA_VALID (valid_o),
        .iDATA_BUSY  (busy_i),
        .oDATA_ROOT  (root_o),
        .oDATA_REM   (rem_o),
        .oCOUNT      (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] erem(input logic [16:0] r);
        return REM_EN ? r : 17'h0;
    endfunction

    // Present one result with radicand = r*r + k.
    task automatic drive(input logic [15:0] r, input logic [31:0] k);
        req    = 1'b1;
        root_i = r;
        rad_i  = 32'(r) * 32'(r) + k;
    endtask

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        req    = 1'b0;
        busy_i = 1'b0;
        root_i = '0;
        rad_i  = '0;
        repeat (2) step();
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_root", root_o, 0);
        chk("rst_rem", rem_o, 0);
        chk("rst_count", count_o, 0);
        rst_n = 1'b1;
        step();

        // single push / pop
        drive(16'h4, 0);
        step();
        req = 1'b0;
        chk("p1_valid", valid_o, 1);
        chk("p1_root", root_o, 16'h4);
        chk("p1_rem", rem_o, 0);
        chk("p1_count", count_o, 1);
        step();
        chk("p1_pop_valid", valid_o, 0);

        // remainder vectors
        busy_i = 1'b1;
        req = 1'b1; root_i = 16'hFFFF; rad_i = 32'hFFFF_FFFF;
        step();
        chk("rem_max", rem_o, erem(17'h1FFFE));
        req = 1'b1; root_i = 16'h4; rad_i = 32'h11;
        step();
        req = 1'b0;
        chk("rem_cnt", count_o, 2);
        busy_i = 1'b0;
        step();
        chk("rem_one_root", root_o, 16'h4);
        chk("rem_one", rem_o, erem(17'h1));
        step();
        chk("rem_drain", valid_o, 0);

        // fill to full with the consumer stalled
        busy_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(16'(i), 32'(i));
            step();
        end
        chk("full_busy", busy_o, 1);
        chk("full_count", count_o, 4);
        drive(16'd5, 32'd5);
        step();
        chk("held_count", count_o, 4);
        chk("held_head", root_o, 1);
        busy_i = 1'b0;
        step();
        busy_i = 1'b1;
        chk("pop_full_count", count_o, 3);
        chk("pop_full_busy", busy_o, 0);
        step();
        req = 1'b0;
        chk("fifth_in", count_o, 4);
        busy_i = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("order_root%0d", k), root_o, 32'(k));
            chk($sformatf("order_rem%0d", k), rem_o, erem(17'(k)));
            step();
        end
        chk("order_empty", valid_o, 0);

        // steady push+pop at occupancy 2
        busy_i = 1'b1;
        drive(16'd10, 0);
        step();
        drive(16'd11, 0);
        step();
        busy_i = 1'b0;
        for (int j = 0; j < 6; j++) begin
            drive(16'(12 + j), 0);
            step();
            chk($sformatf("pp_count%0d", j), count_o, 2);
            chk($sformatf("pp_head%0d", j), root_o, 32'(11 + j));
        end
        req = 1'b0;
        step();
        chk("pp_tail", root_o, 17);
        step();
        chk("pp_empty", valid_o, 0);

        // flush beats push and pop
        busy_i = 1'b1;
        for (int i = 20; i <= 22; i++) begin
            drive(16'(i), 0);
            step();
        end
        chk("fl_pre", count_o, 3);
        busy_i = 1'b0;
        flush  = 1'b1;
        drive(16'd23, 0);
        step();
        flush = 1'b0;
        req   = 1'b0;
        chk("fl_count", count_o, 0);
        chk("fl_valid", valid_o, 0);
        chk("fl_busy", busy_o, 0);
        busy_i = 1'b1;
        drive(16'd24, 3);
        step();
        req = 1'b0;
        chk("fl_next_cnt", count_o, 1);
        chk("fl_next_root", root_o, 24);
        busy_i = 1'b0;
        step();

        // asynchronous reset while full
        busy_i = 1'b1;
        for (int i = 30; i <= 33; i++) begin
            drive(16'(i), 1);
            step();
        end
        req = 1'b0;
        chk("ar_full", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", valid_o, 0);
        chk("ar_busy", busy_o, 0);
        chk("ar_root", root_o, 0);
        chk("ar_rem", rem_o, 0);
        chk("ar_count", count_o, 0);
        #1 rst_n = 1'b1;
        step();
        busy_i = 1'b0;
        drive(16'd9, 2);
        step();
        req = 1'b0;
        chk("ar_push_root", root_o, 9);
        chk("ar_push_rem", rem_o, erem(17'd2));
        chk("ar_push_cnt", count_o, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/square_root32_result_fifo.md
# square_root32_result_fifo

Output stage of the 32-bit pipelined square-root unit. Sits directly downstream of the last `square_root32_element` stage (P_IN_N=32) and captures its 16-bit root and original 32-bit radicand. Computes the remainder (radicand − root²) at capture and holds results in a small show-ahead FIFO. This decouples the pipeline's busy-style backpressure from the result consumer.

## Interface
Parameters:
- P_DEPTH, 4, number of FIFO entries; power of two, ≥2
- P_DEPTH_N, 2, log2(P_DEPTH); pointer width

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  reset, asynchronous, active-low
- iFLUSH  in  1  synchronous flush; empties FIFO
- iDATA_REQ  in  1  last pipeline stage has valid result (its oDATA_VALID)
- oDATA_BUSY  out  1  FIFO full; drives last stage's iDATA_BUSY
- iDATA_ROOT  in  16  root from last stage (its oDATA_P)
- iDATA_I  in  32  radicand from last stage (its oDATA_I)
- oDATA_VALID  out  1  head entry valid
- iDATA_BUSY  in  1  consumer not ready; head is held
- oDATA_ROOT  out  16  head entry root
- oDATA_REM  out  17  head entry remainder
- oCOUNT  out  P_DEPTH_N+1  current occupancy

## Operation
- Storage: P_DEPTH entries of {root[15:0], rem[16:0]}. Write pointer, read pointer and count are all P_DEPTH_N / P_DEPTH_N / P_DEPTH_N+1 bits.
- Pointers wrap modulo P_DEPTH.
- Push: occurs when iDATA_REQ && !oDATA_BUSY && !iFLUSH.
  - Stores iDATA_ROOT.
  - Stores rem = (iDATA_I − iDATA_ROOT*iDATA_ROOT)[16:0], computed as 32-bit unsigned with wrap.
  - Valid root inputs give rem ≤ 2·root, so 17 bits is sufficient. Out-of-range inputs are truncated; no error flag.
- Pop: occurs when oDATA_VALID && !iDATA_BUSY && !iFLUSH. Advances the read pointer.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged, both pointers advance.
- oDATA_BUSY = (count == P_DEPTH). This is a combinational decode of the registered count; there is no path from iDATA_BUSY to oDATA_BUSY.
- Full boundary: while full, iDATA_REQ is not accepted even if a pop occurs in the same cycle. The upstream stage holds its data because of busy. The push succeeds on the next cycle.
- Empty boundary:
  - oDATA_VALID = (count != 0).
  - When empty, oDATA_ROOT/oDATA_REM show the stale entry at the read pointer; the consumer must ignore them.
  - iDATA_BUSY is don't-care when empty.
- oDATA_ROOT/oDATA_REM are a combinational read of the entry at the read pointer (show-ahead).
- iFLUSH takes priority over push and pop in the same cycle:
  - Pointers and count go to 0; entry contents are unchanged.
  - The upstream result presented in that cycle is dropped.
- Reset, including mid-operation: pointers, count and all entries go to 0, and in-flight data is lost.
- Output values during reset and after it: oDATA_VALID=0, oDATA_BUSY=0, oDATA_ROOT=0, oDATA_REM=0, oCOUNT=0.

## Timing
- Push at edge N: oDATA_VALID is high and data is visible after edge N (1-cycle latency from iDATA_REQ to oDATA_VALID).
- Pop at edge N: the next entry, if any, is visible after edge N, giving 1 result per cycle sustained throughput.
- oDATA_BUSY rises after the edge that makes count == P_DEPTH. It falls after the first pop edge.
- The remainder multiplier (16×16) and subtractor are on the push path, from iDATA_ROOT/iDATA_I to entry registers, in a single cycle. There is no extra pipeline stage.
- All state changes on the iCLOCK rising edge, except the asynchronous clear on inRESET falling.

## Configuration
- SQUARE_ROOT32_RESULT_FIFO_REMAINDER_EN:
  - Defined: remainder computed, stored and output as above.
  - Undefined: no multiplier and no rem storage. oDATA_REM is tied to 17'h0, and entries hold root only.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then push radicand 0x00000010 with root 0x0004 → after 1 cycle, oDATA_VALID=1, oDATA_ROOT=0x0004, oDATA_REM=0, oCOUNT=1. Pop with iDATA_BUSY=0 → oDATA_VALID=0.
- Push radicand 0xFFFFFFFF with root 0xFFFF → oDATA_REM=0x1FFFE. Push radicand 0x00000011 with root 0x0004 → oDATA_REM=0x00001. Without the macro, both give oDATA_REM=0.
- iDATA_BUSY=1 and push 5 consecutive results:
  - After 4 pushes, oDATA_BUSY=1 and oCOUNT=4.
  - The 5th result is held, not stored.
  - Release iDATA_BUSY and pop 1 → 5th stored next cycle.
  - Readout order is 1..5.
- At oCOUNT=2, push and pop in the same cycle, repeated for 6 cycles → oCOUNT stays 2, outputs stay in order, and pointers wrap correctly.
- At oCOUNT=3, assert iFLUSH together with iDATA_REQ and a pop → next cycle oCOUNT=0, oDATA_VALID=0, oDATA_BUSY=0, and the flushed-cycle input is absent.
- With FIFO full, assert inRESET low mid-cycle → outputs go to 0 immediately. After release, the first push reads back correctly.
